exit_status_reporter: RTL and testbench

EXIT_STATUS_REPORTER -- requirements
Module: exit_status_reporter

---
 rtl/exit_status_reporter.sv | 139 +++++++++++++
 tb/tb_exit_status_reporter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exit_status_reporter.sv
// Latches a program's exit code on the first rising exit_valid_i edge and
// reports it on LEDs. A non-zero code is blinked MSB-first as long or short pulses.
module exit_status_reporter #(
  parameter int TICK_DIV  = 12500000,
  parameter int CODE_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        clear_i,
  output logic [31:0] exit_value_o,
  output logic        done_led_o,
  output logic        pass_led_o,
  output logic        fail_led_o,
  output logic        code_led_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(CODE_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PASS, S_FAIL_ON, S_FAIL_OFF, S_FAIL_GAP
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_ticks, w_ticks_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [31:0]      r_value, w_value_next;
  logic             r_valid, r_armed;
  logic             r_done, r_pass, r_fail, r_code;
  logic             w_capture, w_tick, w_hold_done;
  logic [1:0]       w_ticks_last;

  // r_armed blocks a level that was already high when reset released from counting as an edge
  assign w_capture   = exit_valid_i && !r_valid && r_armed && !clear_i;
  assign w_tick      = (r_cnt == TICK_LAST);
  assign w_hold_done = w_tick && (r_ticks == w_ticks_last);

  always_comb begin
    w_ticks_last = 2'd0;
    case (r_state)
      S_FAIL_ON:  w_ticks_last = r_value[r_idx] ? 2'd2 : 2'd0;
      S_FAIL_GAP: w_ticks_last = 2'd3;
      default:    w_ticks_last = 2'd0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ticks_next = r_ticks;
    w_idx_next   = r_idx;
    w_value_next = r_value;
    if (clear_i) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_ticks_next = '0;
      w_idx_next   = '0;
      w_value_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            w_value_next = exit_value_i;
            w_cnt_next   = '0;
            w_ticks_next = '0;
            w_idx_next   = IDX_TOP;
            w_state_next = (exit_value_i == 32'd0) ? S_PASS : S_FAIL_ON;
          end
        end
        S_PASS: begin
        end
        default: begin
          w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick) w_ticks_next = r_ticks + 2'd1;
          if (w_hold_done) begin
            w_ticks_next = '0;
            case (r_state)
              S_FAIL_ON: w_state_next = S_FAIL_OFF;
              S_FAIL_OFF: begin
                if (r_idx != '0) begin
                  w_idx_next   = r_idx - 1'b1;
                  w_state_next = S_FAIL_ON;
                end else begin
                  w_state_next = S_FAIL_GAP;
                end
              end
              default: begin
                w_idx_next   = IDX_TOP;
                w_state_next = S_FAIL_ON;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ticks <= '0;
      r_idx   <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ticks <= w_ticks_next;
      r_idx   <= w_idx_next;
      r_value <= w_value_next;
      r_valid <= exit_valid_i;
      r_armed <= r_armed | !exit_valid_i;
      // LEDs decoded from the next state so they toggle cleanly off flops
      r_done  <= (w_state_next != S_IDLE);
      r_pass  <= (w_state_next == S_PASS);
      r_fail  <= (w_state_next == S_FAIL_ON) || (w_state_next == S_FAIL_OFF) ||
                 (w_state_next == S_FAIL_GAP);
      r_code  <= (w_state_next == S_FAIL_ON);
    end
  end

  assign exit_value_o = r_value;
  assign done_led_o   = r_done;
  assign pass_led_o   = r_pass;
  assign fail_led_o   = r_fail;
  assign code_led_o   = r_code;

endmodule

// File: tb/tb_exit_status_reporter.sv
// Bench for exit_status_reporter: directed scenarios with literal blink patterns,
// then randomized traffic checked every cycle against a pattern-based model.
module tb_exit_status_reporter;
  localparam int TD = 4;
  localparam int CB = 4;

  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [31:0] value = 32'd0;
  logic [31:0] dut_value;
  logic        done, pass, fail, code;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  exit_status_reporter #(.TICK_DIV(TD), .CODE_BITS(CB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .exit_valid_i(valid), .exit_value_i(value),
    .clear_i(clear), .exit_value_o(dut_value), .done_led_o(done),
    .pass_led_o(pass), .fail_led_o(fail), .code_led_o(code)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: a captured code maps to one period of LED levels, replayed forever.
  bit          m_active = 0, m_prev = 0, m_seen_low = 0;
  logic [31:0] m_value = 32'd0;
  int          m_t = 0;
  bit          m_pat[$];

  function automatic void build_pattern(input logic [31:0] v);
    m_pat.delete();
    for (int b = CB - 1; b >= 0; b--) begin
      int on_len;
      on_len = v[b] ? 3 * TD : TD;
      for (int k = 0; k < on_len; k++) m_pat.push_back(1'b1);
      for (int k = 0; k < TD; k++) m_pat.push_back(1'b0);
    end
    for (int k = 0; k < 4 * TD; k++) m_pat.push_back(1'b0);
  endfunction

  always @(posedge clk) begin
    bit cap_edge;
    bit exp_code;
    if (!rst_n) begin
      m_active = 0; m_value = 32'd0; m_prev = 0; m_seen_low = 0; m_t = 0;
    end else begin
      cap_edge = valid && !m_prev && m_seen_low;
      if (clear) begin
        m_active = 0; m_value = 32'd0;
      end else if (m_active) begin
        m_t++;
      end else if (cap_edge) begin
        m_active = 1; m_value = value; m_t = 0;
        build_pattern(value);
      end
      m_prev = valid;
      if (!valid) m_seen_low = 1;
    end
    exp_code = (m_active && m_value != 0) ? m_pat[m_t % m_pat.size()] : 1'b0;
    #1;
    check("model_value", dut_value, m_value);
    check("model_done", done, m_active);
    check("model_pass", pass, m_active && m_value == 0);
    check("model_fail", fail, m_active && m_value != 0);
    check("model_code", code, exp_code);
  end

  task automatic trace(input int n, output logic [127:0] t);
    t = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t[127 - i] = code;
    end
  endtask

  initial begin
    logic [127:0] tr;
    logic [63:0]  lit5;
    logic [47:0]  lit100;
    int           ones;
    bit           found;
    lit5   = 64'hF0FF_F0F0_FFF0_0000;
    lit100 = 48'hF0F0_F0F0_0000;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_value", dut_value, 0);
    check("reset_leds", {done, pass, fail, code}, 4'b0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // zero exit code -> pass, no blinking
    value = 32'd0; valid = 1'b1;
    @(negedge clk);
    check("pass_leds", {done, pass, fail}, 3'b110);
    check("pass_value", dut_value, 0);
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ones += int'(code);
    end
    check("pass_code_quiet", ones, 0);

    clear = 1'b1; valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    check("clear_done", done, 0);

    // 0x5 blink, two identical 64-cycle periods
    value = 32'h5; valid = 1'b1;
    trace(128, tr);
    check("blink5_p0", tr[127:64], lit5);
    check("blink5_p1", tr[63:0], lit5);

    // later edges ignored while blinking
    valid = 1'b0;
    @(negedge clk);
    value = 32'h3; valid = 1'b1;
    repeat (2) @(negedge clk);
    check("ignore_value", dut_value, 32'h5);
    check("ignore_fail", fail, 1);

    // clear beats a simultaneous capture edge
    clear = 1'b1; valid = 1'b0;
    @(negedge clk);
    valid = 1'b1; value = 32'h7;
    @(negedge clk);
    clear = 1'b0;
    check("clr_prio_leds", {done, pass, fail, code}, 4'b0000);
    check("clr_prio_value", dut_value, 0);
    @(negedge clk);
    check("clr_no_level_cap", done, 0);
    valid = 1'b0;
    @(negedge clk);
    value = 32'h1; valid = 1'b1;
    @(negedge clk);
    check("after_clr_fail", fail, 1);
    check("after_clr_value", dut_value, 32'h1);

    // reset during FAIL_ON
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = code;
    end
    check("wait_code_on", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midblink_reset_leds", {done, pass, fail, code}, 4'b0000);
    check("midblink_reset_value", dut_value, 0);
    repeat (10) @(negedge clk);
    check("held_high_no_cap", done, 0);
    valid = 1'b0;
    @(negedge clk);
    value = 32'h9; valid = 1'b1;
    @(negedge clk);
    check("recap_value", dut_value, 32'h9);
    check("recap_fail", fail, 1);

    // code with zero low bits still blinks, as all zeros
    clear = 1'b1; valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    value = 32'h100; valid = 1'b1;
    trace(96, tr);
    check("blink100_fail", fail, 1);
    check("blink100_p0", tr[127:80], lit100);
    check("blink100_p1", tr[79:32], lit100);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 24) == 0) valid = ~valid;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) value = 32'd0;
        else if ($urandom_range(0, 1) == 0) value = 32'($urandom_range(1, 15));
        else value = $urandom;
      end
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
